// File: rtl/led_driver_pwm_if.sv
// LED driver bus: CPU-side latch/brightness controls in,
// active-low LED drive and PWM period marker out.
interface led_driver_pwm_if #(
    parameter int WIDTH    = 8,
    parameter int PWM_BITS = 4
);
    logic                load;
    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    blink_mask;
    logic [PWM_BITS-1:0] brightness;
    logic                oe_n;
    logic [WIDTH-1:0]    led_n;
    logic                pwm_sync;

    modport master (
        output load,
        output data,
        output blink_mask,
        output brightness,
        output oe_n,
        input  led_n,
        input  pwm_sync
    );

    modport slave (
        input  load,
        input  data,
        input  blink_mask,
        input  brightness,
        input  oe_n,
        output led_n,
        output pwm_sync
    );
endinterface

// File: rtl/led_driver_pwm.sv
// Registered active-low LED driver with output enable,
// global PWM brightness and per-channel blink.
module led_driver_pwm #(
    parameter int WIDTH     = 8,
    parameter int PWM_BITS  = 4,
    parameter int BLINK_DIV = 1024
) (
    input logic clk,
    input logic rst,
    led_driver_pwm_if.slave bus
);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST =
        BLINK_W'(BLINK_DIV - 1);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    blink_q, blink_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [WIDTH-1:0]    led_n_q, led_n_d;
    logic                pwm_sync_q, pwm_sync_d;

    logic             pwm_wrap;
    logic             blink_wrap;
    logic             pwm_on;
    logic [WIDTH-1:0] lit;

    assign pwm_wrap   = &pwm_cnt_q;
    assign blink_wrap = (blink_cnt_q == BLINK_LAST);
    // All-ones brightness must stay lit on the max count too
    assign pwm_on     = (pwm_cnt_q < bright_q) | (&bright_q);

    always_comb begin
        data_d        = data_q;
        blink_d       = blink_q;
        bright_d      = bright_q;
        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;

        if (bus.load) begin
            data_d  = bus.data;
            blink_d = bus.blink_mask;
        end

        // Brightness only moves on a period boundary
        if (pwm_wrap) begin
            bright_d = bus.brightness;
        end

        if (blink_wrap) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        lit = {WIDTH{~bus.oe_n}} & data_q & {WIDTH{pwm_on}}
            & ~(blink_q & {WIDTH{blink_phase_q}});

        led_n_d    = ~lit;
        pwm_sync_d = pwm_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q        <= '0;
            blink_q       <= '0;
            bright_q      <= '1;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            led_n_q       <= '1;
            pwm_sync_q    <= 1'b0;
        end else begin
            data_q        <= data_d;
            blink_q       <= blink_d;
            bright_q      <= bright_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_n_q       <= led_n_d;
            pwm_sync_q    <= pwm_sync_d;
        end
    end

    assign bus.led_n    = led_n_q;
    assign bus.pwm_sync = pwm_sync_q;
endmodule

// File: tb/tb_led_driver_pwm.sv
// Bench for led_driver_pwm: vector table, hand-written
// corner sequences and a randomized run against a model.
module tb_led_driver_pwm;
    localparam int W  = 8;
    localparam int PB = 4;
    localparam int BD = 4;
    localparam int PER = 1 << PB;

    logic clk;
    logic rst;

    led_driver_pwm_if #(.WIDTH(W), .PWM_BITS(PB)) bus ();

    led_driver_pwm #(
        .WIDTH(W),
        .PWM_BITS(PB),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: state derived from edge count since reset
    int          k_m = 0;
    logic [W-1:0]  m_data = '0;
    logic [W-1:0]  m_blink = '0;
    logic [PB-1:0] m_bright = '1;
    logic [W-1:0]  exp_led = '1;
    logic          exp_sync = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k_m = 0;
            m_data = '0;
            m_blink = '0;
            m_bright = '1;
            exp_led = '1;
            exp_sync = 1'b0;
        end else begin
            int cnt;
            int phase;
            bit on;
            cnt = k_m % PER;
            phase = (k_m / BD) % 2;
            on = (cnt < int'(m_bright)) || (int'(m_bright) == PER - 1);
            for (int i = 0; i < W; i++) begin
                bit lit;
                lit = !bus.oe_n && m_data[i] && on
                      && !(m_blink[i] && phase == 1);
                exp_led[i] = !lit;
            end
            exp_sync = (cnt == PER - 1);
            if (bus.load) begin
                m_data = bus.data;
                m_blink = bus.blink_mask;
            end
            if (cnt == PER - 1) m_bright = bus.brightness;
            k_m++;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model_led", 32'(bus.led_n), 32'(exp_led));
            chk("model_sync", 32'(bus.pwm_sync), 32'(exp_sync));
        end
    end

    typedef struct {
        logic         load;
        logic [W-1:0] data;
        logic         oe_n;
        logic [W-1:0] exp_led;
    } vec_t;

    vec_t tbl[8];

    task automatic wait_sync();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pwm_sync && n < 3 * PER);
        chk("sync_seen", 32'(bus.pwm_sync), 32'd1);
    endtask

    task automatic count_on(input int pos, output int on_cnt,
                            output int off_cnt);
        on_cnt = 0;
        off_cnt = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            if (i == pos) bus.brightness = 4'd12;
            if (bus.led_n == 8'h00) on_cnt++;
            if (bus.led_n == 8'hFF) off_cnt++;
        end
    endtask

    logic [W-1:0] samp[16];

    initial begin
        int on_c;
        int off_c;
        int j;
        logic [W-1:0] other;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h5A};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h5A};
        tbl[2] = '{1'b0, 8'h3C, 1'b1, 8'hFF};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h5A};
        tbl[4] = '{1'b1, 8'h3C, 1'b0, 8'hC3};
        tbl[5] = '{1'b1, 8'hFF, 1'b1, 8'hFF};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 8'h00, 1'b0, 8'hFF};

        rst = 1'b1;
        bus.load = 1'b0;
        bus.data = '0;
        bus.blink_mask = '0;
        bus.brightness = 4'hF;
        bus.oe_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(bus.led_n), 32'hFF);
        chk("reset_sync", 32'(bus.pwm_sync), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Latch and output-enable vectors at full brightness
        foreach (tbl[v]) begin
            bus.load = tbl[v].load;
            bus.data = tbl[v].data;
            bus.oe_n = tbl[v].oe_n;
            @(negedge clk);
            bus.load = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_led", v), 32'(bus.led_n),
                32'(tbl[v].exp_led));
        end

        bus.load = 1'b1;
        bus.data = 8'hA5;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        chk("oe_base", 32'(bus.led_n), 32'h5A);
        bus.oe_n = 1'b1;
        @(negedge clk);
        chk("oe_high_1edge", 32'(bus.led_n), 32'hFF);
        bus.oe_n = 1'b0;
        @(negedge clk);
        chk("oe_low_1edge", 32'(bus.led_n), 32'h5A);

        // PWM duty
        bus.load = 1'b1;
        bus.data = 8'hFF;
        bus.brightness = 4'd4;
        @(negedge clk);
        bus.load = 1'b0;
        wait_sync();
        count_on(-1, on_c, off_c);
        chk("duty4_on", 32'(on_c), 32'd4);
        chk("duty4_off", 32'(off_c), 32'd12);
        chk("duty4_sync_end", 32'(bus.pwm_sync), 32'd1);
        bus.brightness = 4'd0;
        wait_sync();
        count_on(-1, on_c, off_c);
        chk("duty0_on", 32'(on_c), 32'd0);
        chk("duty0_off", 32'(off_c), 32'd16);

        // Brightness change mid-period
        bus.brightness = 4'd4;
        wait_sync();
        count_on(1, on_c, off_c);
        chk("glitch_cur_on", 32'(on_c), 32'd4);
        count_on(-1, on_c, off_c);
        chk("glitch_next_on", 32'(on_c), 32'd12);
        chk("glitch_next_off", 32'(off_c), 32'd4);

        // Blink
        bus.brightness = 4'hF;
        bus.load = 1'b1;
        bus.data = 8'h0F;
        bus.blink_mask = 8'h03;
        @(negedge clk);
        bus.load = 1'b0;
        wait_sync();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            samp[i] = bus.led_n;
        end
        j = 0;
        for (int i = 4; i >= 1; i--)
            if (samp[i] != samp[i-1]) j = i;
        chk("blink_toggle_found", 32'(j != 0), 32'd1);
        if (j == 0) j = 1;
        chk("blink_valid",
            32'(samp[j] == 8'hF0 || samp[j] == 8'hF3), 32'd1);
        other = (samp[j] == 8'hF0) ? 8'hF3 : 8'hF0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("blink_seq%0d", i), 32'(samp[j+i]),
                32'((i / 4) == 0 ? samp[j] : other));
        end

        // Asynchronous reset between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(bus.led_n), 32'hFF);
        chk("async_rst_sync", 32'(bus.pwm_sync), 32'h0);
        @(negedge clk);
        bus.load = 1'b1;
        bus.data = 8'h0F;
        bus.blink_mask = 8'h03;
        rst = 1'b0;
        @(negedge clk);
        bus.load = 1'b0;
        chk("post_rst_data0", 32'(bus.led_n), 32'hFF);
        @(negedge clk);
        chk("post_rst_phase0", 32'(bus.led_n), 32'hF0);
        repeat (3) @(negedge clk);
        chk("post_rst_phase1", 32'(bus.led_n), 32'hF3);

        // Randomized run checked by the model
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            bus.load = ($urandom_range(0, 3) == 0);
            bus.data = W'($urandom);
            bus.blink_mask = W'($urandom);
            case ($urandom_range(0, 3))
                0: bus.brightness = 4'hF;
                1: bus.brightness = 4'h0;
                default: bus.brightness = PB'($urandom);
            endcase
            bus.oe_n = ($urandom_range(0, 4) == 0);
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/led_driver_pwm.md
Name: led_driver_pwm

Overview:
- Parametrised, registered successor to the octal inverting LED buffer.
- Drives WIDTH active-low LED lines from a latched data word, with:
  - a real output-enable (unlike the old buffer, which had none);
  - global PWM brightness;
  - per-channel blink.
- Sits between the CPU-side LED data bus and the board LED sinks in simulation and on hardware.

Parameters:
- WIDTH, 8: number of LED channels.
- PWM_BITS, 4: PWM counter width. Period is 2**PWM_BITS cycles.
- BLINK_DIV, 1024: clock cycles per blink half-period. Must be at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  when high, captures data and blink_mask at the rising edge.
- data  input  WIDTH  LED on/off word; 1 = LED lit.
- blink_mask  input  WIDTH  1 = channel blinks while lit.
- brightness  input  PWM_BITS  requested duty. All ones = full on; 0 = off.
- oe_n  input  1  active-low output enable. When high, all LEDs are forced dark.
- led_n  output  WIDTH  registered active-low LED drive.
- pwm_sync  output  1  one-cycle pulse on the last cycle of each PWM period (pwm_cnt = max).

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - data_q = 0, blink_q = 0, bright_q = all ones.
  - pwm_cnt = 0, blink_cnt = 0, blink_phase = 0.
  - led_n = all ones, pwm_sync = 0.
- Latch:
  - load = 1 at edge N: data_q <= data, blink_q <= blink_mask.
  - load = 0: data_q and blink_q hold.
- PWM counter:
  - pwm_cnt increments every cycle and wraps from 2**PWM_BITS-1 to 0.
  - pwm_sync = 1 exactly when pwm_cnt = 2**PWM_BITS-1. Registered with the same timing as led_n, so it is high on the cycle after the counter reaches max.
- Brightness:
  - bright_q <= brightness only at the wrap edge (pwm_cnt = max). Mid-period changes never alter the current period.
  - pwm_on = (pwm_cnt < bright_q) OR (bright_q = all ones).
  - Resulting on-cycles per period:
    - 0 gives 0 cycles;
    - k gives k cycles;
    - all ones gives 2**PWM_BITS cycles (constant on).
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1.
  - On the edge where blink_cnt = BLINK_DIV-1: blink_cnt <= 0 and blink_phase toggles.
  - blink_phase = 1 is the dark half.
- Output, per channel i, registered:
  - lit_i = ~oe_n & data_q[i] & pwm_on & ~(blink_q[i] & blink_phase).
  - led_n[i] <= ~lit_i.
- Latency:
  - Changes from load, oe_n and counters reach led_n at the edge after the one that updates the internal state.
  - load at edge N appears on led_n after edge N+1.
  - oe_n is sampled combinationally into the output register, so an oe_n change appears at the next edge.
- Counter independence:
  - The PWM and blink counters run regardless of oe_n and load.
  - Asserting oe_n does not reset phase.
- Simultaneous events:
  - load together with the brightness-wrap edge: both updates take effect at that edge.
  - load together with a blink toggle: the new blink_mask applies against the new phase.
- No X propagation: led_n is fully defined from reset onwards.

Test Plan:
1. Reset and load:
   - rst high for 3 cycles → led_n = 8'hFF, pwm_sync = 0.
   - Release, then load data = 8'hA5 with brightness = 4'hF, oe_n = 0, blink_mask = 0 → led_n = 8'h5A from the second edge after load, constant thereafter.
2. Output enable:
   - With 8'hA5 latched, raise oe_n → led_n = 8'hFF one edge later.
   - Lower oe_n → 8'h5A one edge later.
   - Latched data unchanged; no fatal or error.
3. PWM duty:
   - data = 8'hFF, brightness = 4 → each 16-cycle period (aligned to pwm_sync) shows led_n = 8'h00 for exactly 4 cycles and 8'hFF for 12.
   - brightness = 0 → all 16 cycles 8'hFF.
4. Glitch-free brightness update:
   - Change brightness from 4 to 12 at pwm_cnt = 2 → the current period still shows 4 on-cycles; the next period shows 12.
5. Blink:
   - BLINK_DIV = 4, data = 8'h0F, blink_mask = 8'h03, brightness = 4'hF → led_n alternates every 4 cycles between 8'hF0 and 8'hF3.
6. Asynchronous reset mid-operation:
   - Assert rst between edges during case 5 → led_n = 8'hFF immediately (before the next edge).
   - After release, blink_phase restarts at 0 and latched data is 0.
